activation_ctrl: RTL and testbench

Sequences one pass of matmul output rows through the activation unit. Accepts rows from the matmul output stream and issues them to the activation unit, which has no backpressure. Buffers the activated rows in a small in-order FIFO for the output writer. Uses credit-based issue so no activated row is ever dropped, whatever the activation latency.

---
 rtl/activation_ctrl.sv | 147 ++++++++++++++
 tb/tb_activation_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/activation_ctrl.sv
// Credit-based sequencer moving matmul rows through the activation unit into an in-order output FIFO.
// Optional ACT_STALL_CNT_EN adds a saturating stall_cycles counter output.
module activation_ctrl #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int MASK_WIDTH   = 4,
    parameter int ROWS_WIDTH   = 8,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [ROWS_WIDTH-1:0]          num_rows,
    input  logic                           enable_act_cfg,
    input  logic [MASK_WIDTH-1:0]          mask_cfg,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    input  logic                           mm_valid,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] mm_data,
    output logic                           mm_ready,
    output logic                           act_enable,
    output logic [MASK_WIDTH-1:0]          act_mask,
    output logic                           act_in_valid,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] act_in_data,
    input  logic                           act_out_valid,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] act_out_data,
    output logic                           wr_valid,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] wr_data,
    input  logic                           wr_ready
`ifdef ACT_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int RW = MAT_MUL_SIZE * DWIDTH;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ROWS_WIDTH-1:0] rows_q, issued, written, issued_inc;
    logic [CW-1:0]         inflight, fifo_count;
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [RW-1:0]         mem [BUF_DEPTH];
    logic [CW:0]           occupancy;
    logic                  credit, accept, issue, push, pop, stray;

    // A row may only be issued if a FIFO slot is already reserved for its result.
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
        credit     = occupancy < (CW+1)'(BUF_DEPTH);
        accept     = start && (state == IDLE);
        mm_ready   = (state == RUN) && credit;
        issue      = mm_valid && mm_ready;
        issued_inc = issued + 1'b1;
        push       = act_out_valid && (inflight != '0);
        stray      = act_out_valid && (inflight == '0);
        wr_valid   = (fifo_count != '0);
        wr_data    = mem[rd_ptr];
        pop        = wr_valid && wr_ready;
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_rows != '0) ? RUN : DONE;
            RUN:     if (issue && (issued_inc == rows_q)) state_nxt = DRAIN;
            DRAIN:   if ((inflight == '0) && (fifo_count == '0) && (written == rows_q))
                         state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            rows_q       <= '0;
            issued       <= '0;
            written      <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            err          <= 1'b0;
            act_enable   <= 1'b0;
            act_mask     <= '0;
            act_in_valid <= 1'b0;
            act_in_data  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            state        <= state_nxt;
            act_in_valid <= issue;
            if (issue) act_in_data <= mm_data;

            if (accept) begin
                rows_q     <= num_rows;
                act_enable <= enable_act_cfg;
                act_mask   <= mask_cfg;
                issued     <= '0;
                written    <= '0;
            end else begin
                if (issue) issued <= issued_inc;
                if (pop)   written <= written + 1'b1;
            end

            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            // A result with no matching issue is flagged and dropped.
            if (stray) err <= 1'b1;

            if (push) begin
                mem[wr_ptr] <= act_out_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef ACT_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if ((state == RUN) && mm_valid && !mm_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_activation_ctrl.sv
// Scoreboard bench for activation_ctrl: random passes through a delay-line activation model,
// ordered result checking, plus reset, backpressure, zero-row, busy-start and error scenarios.
module tb_activation_ctrl;

    localparam int RW = 32;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          resetn, start, enable_act_cfg;
    logic [7:0]    num_rows;
    logic [3:0]    mask_cfg;
    logic          busy, done, err;
    logic          mm_valid, mm_ready;
    logic [RW-1:0] mm_data;
    logic          act_enable, act_in_valid, act_out_valid;
    logic [3:0]    act_mask;
    logic [RW-1:0] act_in_data, act_out_data;
    logic          wr_valid, wr_ready;
    logic [RW-1:0] wr_data;
`ifdef ACT_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int            checks = 0;
    int            fails  = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] rows [16];
    int            pop_cnt = 0, done_cnt = 0, ain_cnt = 0;
    int            held_issues = 0;
    logic          held_ready = 1'b0;
    int            lat_sel = 0;
    logic          inject = 1'b0;
    logic          dly_v = 1'b0;
    logic [RW-1:0] dly_d = '0;
    logic [7:0]    pipe_v = '0;
    logic [RW-1:0] pipe_d [8];

    activation_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
        .enable_act_cfg(enable_act_cfg), .mask_cfg(mask_cfg),
        .busy(busy), .done(done), .err(err),
        .mm_valid(mm_valid), .mm_data(mm_data), .mm_ready(mm_ready),
        .act_enable(act_enable), .act_mask(act_mask),
        .act_in_valid(act_in_valid), .act_in_data(act_in_data),
        .act_out_valid(act_out_valid), .act_out_data(act_out_data),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef ACT_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Activation unit model: identity transform delayed by lat_sel cycles, no backpressure.
    assign act_out_valid = inject | ((lat_sel == 0) ? act_in_valid : dly_v);
    assign act_out_data  = (lat_sel == 0) ? act_in_data : dly_d;

    initial begin
        for (int i = 0; i < 8; i++) pipe_d[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (lat_sel > 0) begin
                dly_v = pipe_v[lat_sel-1];
                dly_d = pipe_d[lat_sel-1];
            end else begin
                dly_v = 1'b0;
            end
            for (int i = 7; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = act_in_valid;
            pipe_d[0] = act_in_data;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every writer handshake must match the oldest accepted row.
    initial begin
        forever begin
            @(negedge clk);
            if (act_in_valid) ain_cnt++;
            if (done) done_cnt++;
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pop_with_model_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    checkOutput("wr_data_order", 64'(wr_data), 64'(exp_q.pop_front()));
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputsZero(input string name);
        @(negedge clk);
        checkOutput(name, 64'({busy, done, mm_ready, act_in_valid, wr_valid, act_enable,
                               act_mask, act_in_data, err}), 64'd0);
        tick();
    endtask

    task automatic applyStimulus(input int n, input int lat, input int pv, input int pr,
                                 input int hold, input bit mid_start, input bit use_fixed);
        bit         en;
        logic [3:0] mask;
        int         idx, cyc;
        bit         fin;
        repeat (8) tick();
        lat_sel = lat;
        en      = 1'($urandom_range(1));
        mask    = 4'($urandom_range(15));
        if (!use_fixed) for (int i = 0; i < 16; i++) rows[i] = $urandom();
        pop_cnt = 0; done_cnt = 0; ain_cnt = 0;
        held_issues = -1; held_ready = 1'b1;
        start = 1'b1; num_rows = 8'(n); enable_act_cfg = en; mask_cfg = mask;
        mm_valid = 1'b0; wr_ready = 1'b0;
        tick();
        start = 1'b0; num_rows = mid_start ? 8'd5 : 8'($urandom_range(255));
        enable_act_cfg = ~en; mask_cfg = ~mask;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 600) begin
            mm_valid = (idx < n) && ($urandom_range(99) < pv);
            mm_data  = (idx < n) ? rows[idx] : $urandom();
            wr_ready = (cyc >= hold) && ($urandom_range(99) < pr);
            start    = mid_start && (cyc == 1);
            @(negedge clk);
            if (mm_valid && mm_ready) begin
                exp_q.push_back(mm_data);
                idx++;
            end
            if (hold > 0 && cyc == hold - 1) begin
                held_issues = idx;
                held_ready  = mm_ready;
            end
            tick();
            cyc++;
            if (done_cnt > 0) fin = 1'b1;
        end
        checkOutput("pass_done_within_budget", 64'(fin), 64'd1);
        start = 1'b0; mm_valid = 1'b0;
        repeat (3) tick();
        checkOutput("done_pulse_count", 64'(done_cnt), 64'd1);
        checkOutput("rows_delivered", 64'(pop_cnt), 64'(n));
        checkOutput("rows_issued_to_act", 64'(ain_cnt), 64'(n));
        checkOutput("rows_accepted", 64'(idx), 64'(n));
        checkOutput("model_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("err_clear", 64'(err), 64'd0);
        checkOutput("act_enable_latched", 64'(act_enable), 64'(en));
        checkOutput("act_mask_latched", 64'(act_mask), 64'(mask));
    endtask

    initial begin
        resetn = 1'b0; start = 1'b1; num_rows = 8'd3; enable_act_cfg = 1'b1;
        mask_cfg = 4'hF; mm_valid = 1'b1; mm_data = 32'hDEADBEEF; wr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) checkIdleOutputsZero("reset_outputs_zero");
        resetn = 1'b1; start = 1'b0; mm_valid = 1'b0;
        for (int i = 0; i < 2; i++) checkIdleOutputsZero("post_reset_idle_zero");

        rows[0] = 32'h11111111; rows[1] = 32'h22222222; rows[2] = 32'h33333333;
        applyStimulus(3, 0, 100, 100, 0, 1'b0, 1'b1);

        // Writer stalled: credits must cap in-flight plus buffered rows at the FIFO depth.
        applyStimulus(8, 3, 100, 100, 20, 1'b0, 1'b0);
        checkOutput("issues_before_credit_stall", 64'(held_issues), 64'(BD));
        checkOutput("mm_ready_low_when_full", 64'(held_ready), 64'd0);
`ifdef ACT_STALL_CNT_EN
        checkOutput("stall_cycles_counted", 64'(stall_cycles >= 32'd10), 64'd1);
`endif

        applyStimulus(0, 1, 100, 100, 0, 1'b0, 1'b0);
`ifdef ACT_STALL_CNT_EN
        checkOutput("stall_cleared_by_start", 64'(stall_cycles), 64'd0);
`endif

        applyStimulus(2, 2, 100, 100, 0, 1'b1, 1'b0);

        for (int p = 0; p < 10; p++)
            applyStimulus($urandom_range(12, 1), $urandom_range(4), $urandom_range(100, 30),
                          $urandom_range(100, 30), 0, 1'b0, 1'b0);

        // Spurious activation result in IDLE: sticky error, nothing buffered.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        checkOutput("err_set_on_stray", 64'(err), 64'd1);
        checkOutput("fifo_empty_after_stray", 64'(wr_valid), 64'd0);
        repeat (5) tick();
        @(negedge clk);
        checkOutput("err_sticky", 64'(err), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("err_cleared_by_reset", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
